// File: rtl/uart_receiver_if.sv
// Receive-side result bundle: byte, error flags and the one-cycle valid strobe
// delivered from the UART receiver to the register/controller side.
interface uart_receiver_if #(
    parameter int DATA_UART = 8
);
    logic [DATA_UART-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx_data, rx_valid, parity_err, frame_err, busy);
    modport slave  (input  rx_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: synchronizes and oversamples rx_i with the shared baud divisor,
// checks start/parity/stop bits and emits each byte as a one-cycle valid pulse.
module uart_receiver #(
    parameter int DIV_SIZE  = 16,
    parameter int DATA_UART = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic                stop_bits_i,
    input  logic                parity_bit_i,
    input  logic                parity_bit_mode_i,
    input  logic [DIV_SIZE-1:0] baud_div_i,
    input  logic                rx_i,
    uart_receiver_if.master     rx_if
);
    localparam int BCW = $clog2(DATA_UART + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;

    state_e               state_q, state_d;
    logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
    logic [BCW-1:0]       bitCnt_q, bitCnt_d;
    logic [DATA_UART-1:0] shift_q, shift_d;
    logic                 parErr_q, parErr_d;
    logic                 frmErr_q, frmErr_d;
    logic                 stopCnt_q, stopCnt_d;
    logic [DATA_UART-1:0] rxData_q, rxData_d;
    logic                 rxValid_q, rxValid_d;
    logic                 parityErrOut_q, parityErrOut_d;
    logic                 frameErrOut_q, frameErrOut_d;
    logic                 busy_q, busy_d;
    logic                 rxMeta_q, rxSync_q;

    logic [DIV_SIZE-1:0]  half;
    logic [DIV_SIZE-1:0]  cntInc;
    logic                 bitTick;
    logic                 expParity;

    assign half      = baud_div_i >> 1;
    assign cntInc    = cnt_q + {{(DIV_SIZE-1){1'b0}}, 1'b1};
    assign bitTick   = (cnt_q == baud_div_i);
    assign expParity = parity_bit_mode_i ? (^shift_q) : ~(^shift_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rxMeta_q       <= 1'b1;
            rxSync_q       <= 1'b1;
            state_q        <= IDLE;
            cnt_q          <= '0;
            bitCnt_q       <= '0;
            shift_q        <= '0;
            parErr_q       <= 1'b0;
            frmErr_q       <= 1'b0;
            stopCnt_q      <= 1'b0;
            rxData_q       <= '0;
            rxValid_q      <= 1'b0;
            parityErrOut_q <= 1'b0;
            frameErrOut_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            rxMeta_q       <= rx_i;
            rxSync_q       <= rxMeta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bitCnt_q       <= bitCnt_d;
            shift_q        <= shift_d;
            parErr_q       <= parErr_d;
            frmErr_q       <= frmErr_d;
            stopCnt_q      <= stopCnt_d;
            rxData_q       <= rxData_d;
            rxValid_q      <= rxValid_d;
            parityErrOut_q <= parityErrOut_d;
            frameErrOut_q  <= frameErrOut_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bitCnt_d       = bitCnt_q;
        shift_d        = shift_q;
        parErr_d       = parErr_q;
        frmErr_d       = frmErr_q;
        stopCnt_d      = stopCnt_q;
        rxData_d       = rxData_q;
        rxValid_d      = 1'b0;
        parityErrOut_d = parityErrOut_q;
        frameErrOut_d  = frameErrOut_q;
        busy_d         = busy_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i && !rxSync_q) begin
                    state_d   = START;
                    busy_d    = 1'b1;
                    bitCnt_d  = '0;
                    parErr_d  = 1'b0;
                    frmErr_d  = 1'b0;
                    stopCnt_d = 1'b0;
                end
            end
            // Half a bit in: a line already back high was only a glitch.
            START: begin
                if (cnt_q == half) begin
                    cnt_d = '0;
                    if (rxSync_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end
            DATA: begin
                if (bitTick) begin
                    cnt_d                = '0;
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_UART-1] = rxSync_q;
                    bitCnt_d             = bitCnt_q + {{(BCW-1){1'b0}}, 1'b1};
                    if (bitCnt_q == BCW'(DATA_UART - 1)) begin
                        state_d = parity_bit_i ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end
            PARITY: begin
                if (bitTick) begin
                    cnt_d    = '0;
                    state_d  = STOP;
                    parErr_d = (rxSync_q != expParity);
                end else begin
                    cnt_d = cntInc;
                end
            end
            STOP: begin
                if (bitTick) begin
                    cnt_d = '0;
                    if (!stop_bits_i || stopCnt_q) begin
                        rxData_d       = shift_q;
                        parityErrOut_d = parErr_q;
                        frameErrOut_d  = frmErr_q | ~rxSync_q;
                        rxValid_d      = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = rxSync_q ? IDLE : WAIT_HIGH;
                    end else begin
                        stopCnt_d = 1'b1;
                        frmErr_d  = frmErr_q | ~rxSync_q;
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_if.rx_data    = rxData_q;
    assign rx_if.rx_valid   = rxValid_q;
    assign rx_if.parity_err = parityErrOut_q;
    assign rx_if.frame_err  = frameErrOut_q;
    assign rx_if.busy       = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are driven bit by bit, expected results
// come from a counting-based frame model, and a monitor checks every rx_valid pulse.
module tb_uart_receiver;
    localparam int DIV_SIZE  = 16;
    localparam int DATA_UART = 8;

    logic                clk = 1'b0;
    logic                rstn;
    logic                en;
    logic                stopBits;
    logic                parityEn;
    logic                parityMode;
    logic [DIV_SIZE-1:0] baudDiv;
    logic                rx;

    uart_receiver_if #(.DATA_UART(DATA_UART)) rxIf ();

    uart_receiver #(.DIV_SIZE(DIV_SIZE), .DATA_UART(DATA_UART)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .en_i             (en),
        .stop_bits_i      (stopBits),
        .parity_bit_i     (parityEn),
        .parity_bit_mode_i(parityMode),
        .baud_div_i       (baudDiv),
        .rx_i             (rx),
        .rx_if            (rxIf.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } expect_t;

    expect_t expQ[$];
    int      vecCount   = 0;
    int      missCount  = 0;
    int      busyCycles = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: parity is judged by counting ones over data plus the parity bit.
    function automatic expect_t modelFrame(input logic [7:0] data, input logic pbit,
                                           input logic s1, input logic s2);
        expect_t e;
        int ones;
        ones   = $countones(data) + int'(pbit);
        e.data = data;
        e.perr = parityEn && (((ones % 2) == 0) != parityMode);
        e.ferr = !s1 || (stopBits && !s2);
        return e;
    endfunction

    function automatic logic goodParity(input logic [7:0] data);
        int ones;
        ones = $countones(data);
        return parityMode ? logic'(ones % 2) : logic'((ones + 1) % 2);
    endfunction

    task automatic driveBit(input logic b);
        rx = b;
        repeat (int'(baudDiv) + 1) @(negedge clk);
    endtask

    task automatic driveFrame(input logic [7:0] data, input logic pbit, input logic s1, input logic s2);
        driveBit(1'b0);
        for (int i = 0; i < DATA_UART; i++) driveBit(data[i]);
        if (parityEn) driveBit(pbit);
        driveBit(s1);
        if (stopBits) driveBit(s2);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic pbit, input logic s1, input logic s2);
        expQ.push_back(modelFrame(data, pbit, s1, s2));
        driveFrame(data, pbit, s1, s2);
    endtask

    task automatic idleLine(input int bits);
        rx = 1'b1;
        repeat (bits * (int'(baudDiv) + 1)) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rxIf.busy) busyCycles++;
    end

    expect_t gotExp;
    logic    prevValid = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rxIf.rx_valid) begin
            if (prevValid) checkOutput("valid_width", 32'd1, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                gotExp = expQ.pop_front();
                checkOutput("rx_data", 32'(rxIf.rx_data), 32'(gotExp.data));
                checkOutput("parity_err", 32'(rxIf.parity_err), 32'(gotExp.perr));
                checkOutput("frame_err", 32'(rxIf.frame_err), 32'(gotExp.ferr));
                checkOutput("busy_at_valid", 32'(rxIf.busy), 32'd0);
            end
        end
        prevValid = rxIf.rx_valid;
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_data"}, 32'(rxIf.rx_data), 32'd0);
        checkOutput({tag, "_rx_valid"}, 32'(rxIf.rx_valid), 32'd0);
        checkOutput({tag, "_parity_err"}, 32'(rxIf.parity_err), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(rxIf.frame_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(rxIf.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       pb, s1, s2;
        logic [7:0] abortByte;

        rstn = 1'b0; rx = 1'b1; en = 1'b1;
        stopBits = 1'b0; parityEn = 1'b0; parityMode = 1'b0; baudDiv = 16'd15;
        repeat (3) @(negedge clk);
        #1 checkResetValues("reset");
        @(negedge clk) rstn = 1'b1;
        repeat (4) @(negedge clk);

        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        idleLine(2);
        checkOutput("busy_after_a5", 32'(rxIf.busy), 32'd0);

        parityEn = 1'b1; parityMode = 1'b1; stopBits = 1'b1;
        applyStimulus(8'h3C, goodParity(8'h3C), 1'b1, 1'b1);
        applyStimulus(8'h81, goodParity(8'h81), 1'b1, 1'b1);
        idleLine(2);

        parityMode = 1'b0; stopBits = 1'b0;
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b1);
        idleLine(2);

        parityEn = 1'b0;
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0);
        busyCycles = 0;
        repeat (40) @(negedge clk);
        checkOutput("busy_during_break", 32'(busyCycles), 32'd0);
        idleLine(2);
        applyStimulus(8'h12, 1'b0, 1'b1, 1'b1);
        idleLine(2);

        busyCycles = 0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("glitch_busy_seen", 32'(busyCycles > 0), 32'd1);
        checkOutput("glitch_busy_end", 32'(rxIf.busy), 32'd0);

        abortByte = 8'hF0;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(abortByte[i]);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1 checkResetValues("midreset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(8'h0F, 1'b0, 1'b1, 1'b1);
        idleLine(2);

        en = 1'b0;
        busyCycles = 0;
        driveFrame(8'h66, 1'b0, 1'b1, 1'b1);
        idleLine(2);
        checkOutput("disabled_busy", 32'(busyCycles), 32'd0);
        en = 1'b1;

        for (int n = 0; n < 12; n++) begin
            baudDiv    = 16'($urandom_range(3, 20));
            parityEn   = 1'($urandom_range(0, 1));
            parityMode = 1'($urandom_range(0, 1));
            stopBits   = 1'($urandom_range(0, 1));
            d          = 8'($urandom_range(0, 255));
            pb         = ($urandom_range(0, 3) == 0) ? ~goodParity(d) : goodParity(d);
            s1         = ($urandom_range(0, 4) != 0);
            s2         = ($urandom_range(0, 4) != 0);
            repeat (3) @(negedge clk);
            applyStimulus(d, pb, s1, s2);
            idleLine(3);
        end

        checkOutput("pending_expect", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive path of the AXI-lite UART IP core. Oversamples the asynchronous serial input with the same baud divisor the transmit path uses, checks the start bit, and shifts in LSB-first data, optional parity and one or two stop bits. Delivers each completed byte to the register/controller side as a one-cycle valid pulse with parity and framing error flags. Frame format and bit period are identical to the core's transmit path, so TX looped to RX returns the sent byte.

## Interface
- DIV_SIZE, 16, width of the baud divisor
- DATA_UART, 8, data bits per frame (1..15)

- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous, active-low reset
- en_i  in  1  receiver enable; gates start-bit detection only
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
- parity_bit_i  in  1  1 = parity bit present after data
- parity_bit_mode_i  in  1  0 = odd, 1 = even
- baud_div_i  in  DIV_SIZE  bit period = baud_div_i+1 clk cycles; must be ≥ 3
- rx_i  in  1  serial input, asynchronous, idle high
- rx_data_o  out  DATA_UART  last received data, LSB = first bit on the line
- rx_valid_o  out  1  one-cycle pulse: rx_data_o and error flags updated
- parity_err_o  out  1  parity mismatch on the last frame (0 if parity disabled)
- frame_err_o  out  1  any sampled stop bit was 0 on the last frame
- busy_o  out  1  high from start detection until return to IDLE

## Operation
- rx_i passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
- Bit counter cnt (DIV_SIZE bits), half = baud_div_i >> 1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: cnt=0. If en_i && rx_s==0 -> START, busy_o=1.
- START: cnt increments. At cnt==half: rx_s==1 -> false start, IDLE, busy_o=0; rx_s==0 -> DATA, cnt=0.
- DATA: at cnt==baud_div_i sample rx_s into the MSB of the shift register (right shift), cnt=0, bitcount++; after DATA_UART samples -> PARITY if parity_bit_i, else STOP. Otherwise cnt++.
- PARITY: at cnt==baud_div_i sample the parity bit, cnt=0 -> STOP. Expected parity: even -> XOR(data), odd -> ~XOR(data); mismatch sets the internal error bit.
- STOP: at cnt==baud_div_i sample; any 0 sets the internal frame error. After 1 (stop_bits_i=0) or 2 (stop_bits_i=1) samples: load rx_data_o, parity_err_o, frame_err_o, pulse rx_valid_o, busy_o=0, next state IDLE if the last sample was 1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE (no start detection during a break).
- Config inputs are sampled live; software changes them only while busy_o==0.
- en_i deasserted mid-frame: frame completes normally.
- rx_data_o/flags hold until the next rx_valid_o; no overrun detection, consumer must take data on the pulse.

## Timing
- Reset (async assert, sync deassert use): state IDLE, rx_data_o=0, rx_valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, cnt=0, synchronizer=1.
- Reset mid-frame: immediate return to reset values, no rx_valid_o.
- Start detect: 2 cycles after the rx_i falling edge (synchronizer), busy_o rises the following cycle.
- Start bit verified half+1 cycles after START entry; each later sample at (baud_div_i+1)-cycle intervals, i.e. near mid-bit.
- rx_valid_o asserts the cycle after the final stop-bit sample, i.e. mid-way through the last stop bit; receiver re-arms in the same cycle.
- rx_valid_o is exactly one cycle wide; never asserted for false starts.

## Test plan
- baud_div_i=15, no parity, 1 stop, send 0xA5 -> one rx_valid_o, rx_data_o=0xA5, parity_err_o=0, frame_err_o=0, busy_o low afterwards.
- Even parity, 2 stop bits, back-to-back 0x3C then 0x81 with correct parity -> two pulses, data 0x3C, 0x81, no errors; second start not missed.
- Odd parity, send 0x01 with parity bit 1 (wrong) -> rx_data_o=0x01, parity_err_o=1.
- Send 0x55 with stop bit driven 0, line held low 40 cycles -> frame_err_o=1, state WAIT_HIGH, no new frame until line high, next good frame 0x12 received with frame_err_o=0.
- 3-cycle low glitch on idle line (baud_div_i=15) -> busy_o pulses, no rx_valid_o, receiver returns to IDLE.
- Assert rstn_i low mid-DATA of 0xF0 -> all outputs at reset values, no rx_valid_o; next frame 0x0F received correctly.
